// File: rtl/ovport_sched.sv
// Per-output-port frame scheduler: strict class priority (rresp > rreq > wreq) with
// round-robin across ingress ports, atomic frame grants, wreq aging and idle-gap timeout.
module ovport_sched #(
   parameter int PORT_NUM     = 4,
   parameter int OVPORT_ADR   = 0,
   parameter int ADR_WIDTH    = 20,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16,
   localparam int IDX_W       = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORT_NUM-1:0]           req_valid,
   input  logic [PORT_NUM*ADR_WIDTH-1:0] req_dst,
   input  logic [PORT_NUM*2-1:0]         req_class,
   input  logic [PORT_NUM-1:0]           req_last,
   output logic [PORT_NUM-1:0]           req_ready,
   input  logic                          tx_ready,
   output logic                          tx_valid,
   output logic                          tx_last,
   output logic [PORT_NUM-1:0]           grant,
   output logic [IDX_W-1:0]              grant_idx,
   output logic                          busy,
   output logic                          abort
);

   localparam int ST_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state_q, state_d;
   logic [PORT_NUM-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ST_W-1:0]     starve_q, starve_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                abort_q, abort_d;

   logic [PORT_NUM-1:0] wreq_m, rreq_m, rresp_m, cls_m;
   logic                sel_wreq, win_found, xfer;
   logic [IDX_W-1:0]    win_idx, cand;

   genvar gi;
   generate
      for (gi = 0; gi < PORT_NUM; gi++) begin : g_elig
         logic       elig;
         logic [1:0] cls;
         assign cls         = req_class[gi*2 +: 2];
         assign elig        = req_valid[gi]
                              && (req_dst[gi*ADR_WIDTH +: ADR_WIDTH] == ADR_WIDTH'(OVPORT_ADR));
         assign wreq_m[gi]  = elig && (cls == 2'd0);
         assign rreq_m[gi]  = elig && (cls == 2'd1);
         assign rresp_m[gi] = elig && (cls == 2'd2);
      end
   endgenerate

   // Aging overrides class priority once wreq has been bypassed STARVE_LIMIT times.
   always_comb begin
      cls_m    = wreq_m;
      sel_wreq = 1'b1;
      if ((STARVE_LIMIT != 0) && (starve_q == ST_W'(STARVE_LIMIT)) && (|wreq_m)) begin
         cls_m    = wreq_m;
         sel_wreq = 1'b1;
      end else if (|rresp_m) begin
         cls_m    = rresp_m;
         sel_wreq = 1'b0;
      end else if (|rreq_m) begin
         cls_m    = rreq_m;
         sel_wreq = 1'b0;
      end
   end

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= PORT_NUM; k++) begin
         cand = IDX_W'((int'(rr_ptr_q) + k) % PORT_NUM);
         if (!win_found && cls_m[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      tx_valid  = 1'b0;
      tx_last   = 1'b0;
      if (!rst && (state_q == BUSY)) begin
         tx_valid             = req_valid[grant_idx_q];
         tx_last              = req_last[grant_idx_q];
         req_ready[grant_idx_q] = req_valid[grant_idx_q] & tx_ready;
      end
   end

   assign xfer = tx_valid & tx_ready;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;
      starve_d    = starve_q;
      gap_d       = gap_q;
      abort_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d     = BUSY;
               grant_d     = PORT_NUM'(1) << win_idx;
               grant_idx_d = win_idx;
               rr_ptr_d    = win_idx;
               gap_d       = '0;
               if (sel_wreq)
                  starve_d = '0;
               else if ((|wreq_m) && (starve_q != ST_W'(STARVE_LIMIT)))
                  starve_d = starve_q + 1'b1;
            end
         end
         BUSY: begin
            if (xfer) begin
               gap_d = '0;
               if (tx_last) begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if ((TIMEOUT != 0) && (gap_q == GAP_W'(TIMEOUT - 1))) begin
               // rr_ptr stays on the aborted port so it is searched last next time.
               state_d = IDLE;
               grant_d = '0;
               gap_d   = '0;
               abort_d = 1'b1;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         grant_idx_q <= '0;
         rr_ptr_q    <= IDX_W'(PORT_NUM - 1);
         starve_q    <= '0;
         gap_q       <= '0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         starve_q    <= starve_d;
         gap_q       <= gap_d;
         abort_q     <= abort_d;
      end
   end

   assign grant     = grant_q;
   assign grant_idx = grant_idx_q;
   assign busy      = (state_q == BUSY);
   assign abort     = abort_q;

endmodule

// File: tb/tb_ovport_sched.sv
// Directed bench for ovport_sched: reset, single frame, incast, class priority,
// wreq aging, idle timeout with abort, stall and reset mid-frame.
module tb_ovport_sched;

   localparam int PN = 4;
   localparam int AW = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic [PN-1:0] req_valid;
   logic [PN*AW-1:0] req_dst;
   logic [PN*2-1:0]  req_class;
   logic [PN-1:0] req_last;
   logic [PN-1:0] req_ready;
   logic          tx_ready;
   logic          tx_valid;
   logic          tx_last;
   logic [PN-1:0] grant;
   logic [1:0]    grant_idx;
   logic          busy;
   logic          abort;

   int n_cmp = 0;
   int n_err = 0;

   ovport_sched #(
      .PORT_NUM(PN), .OVPORT_ADR(2), .ADR_WIDTH(AW), .STARVE_LIMIT(2), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_dst(req_dst),
      .req_class(req_class), .req_last(req_last), .req_ready(req_ready),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_last(tx_last),
      .grant(grant), .grant_idx(grant_idx), .busy(busy), .abort(abort)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic v, input int d, input int c, input logic l);
      req_valid[p]         = v;
      req_dst[p*AW +: AW]  = AW'(d);
      req_class[p*2 +: 2]  = 2'(c);
      req_last[p]          = l;
   endtask

   task automatic clear_all();
      for (int p = 0; p < PN; p++) set_port(p, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      tx_ready = 1'b1;
      for (int p = 0; p < PN; p++) set_port(p, 1'b1, 2, 0, 1'b1);
      #1;
      // 1: reset with every input active
      check("rst_rdy_comb", req_ready, 4'h0);
      check("rst_txv_comb", tx_valid, 1'b0);
      tick(); tick(); tick();
      check("rst_grant", grant, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_idx", grant_idx, 2'd0);
      check("rst_abort", abort, 1'b0);
      check("rst_rdy", req_ready, 4'h0);
      check("rst_txv", tx_valid, 1'b0);
      clear_all();
      rst = 1'b0;

      // Ineligible: class 3 and wrong destination never get a grant
      set_port(0, 1'b1, 2, 3, 1'b1);
      set_port(1, 1'b1, 5, 1, 1'b1);
      tick(); tick();
      check("inelig_grant", grant, 4'h0);
      check("inelig_busy", busy, 1'b0);
      clear_all();
      tick();

      // 2: single 3-beat rreq frame on p0
      do_reset();
      set_port(0, 1'b1, 2, 1, 1'b0);
      #1;
      check("f2_pre_grant", grant, 4'h0);
      tick();
      check("f2_grant", grant, 4'h1);
      check("f2_busy", busy, 1'b1);
      check("f2_rdy1", req_ready, 4'h1);
      check("f2_last1", tx_last, 1'b0);
      tick();
      check("f2_rdy2", req_ready, 4'h1);
      set_port(0, 1'b1, 2, 1, 1'b1);
      #1;
      check("f2_rdy3", req_ready, 4'h1);
      check("f2_last3", tx_last, 1'b1);
      tick();
      clear_all();
      #1;
      check("f2_idle_grant", grant, 4'h0);
      check("f2_idle_busy", busy, 1'b0);

      // 3: incast p0 and p3, 2-beat frames, with a stall on p3
      do_reset();
      set_port(0, 1'b1, 2, 1, 1'b0);
      set_port(3, 1'b1, 2, 1, 1'b0);
      tick();
      check("ic_grant0", grant, 4'h1);
      check("ic_rdy0a", req_ready, 4'h1);
      tick();
      set_port(0, 1'b1, 2, 1, 1'b1);
      #1;
      check("ic_hold0", grant, 4'h1);
      check("ic_rdy0b", req_ready, 4'h1);
      tick();
      set_port(0, 1'b0, 2, 1, 1'b0);
      #1;
      check("ic_bubble", grant, 4'h0);
      check("ic_bubble_rdy", req_ready, 4'h0);
      tick();
      check("ic_grant3", grant, 4'h8);
      check("ic_idx3", grant_idx, 2'd3);
      tx_ready = 1'b0;
      #1;
      check("ic_stall_rdy", req_ready, 4'h0);
      check("ic_stall_txv", tx_valid, 1'b1);
      tick();
      tx_ready = 1'b1;
      #1;
      check("ic_stall_hold", grant, 4'h8);
      check("ic_rdy3a", req_ready, 4'h8);
      tick();
      set_port(3, 1'b1, 2, 1, 1'b1);
      #1;
      check("ic_last3", tx_last, 1'b1);
      tick();
      clear_all();
      #1;
      check("ic_done", busy, 1'b0);

      // 4: rresp beats wreq
      set_port(1, 1'b1, 2, 0, 1'b1);
      set_port(2, 1'b1, 2, 2, 1'b1);
      tick();
      check("pri_rresp", grant, 4'h4);
      tick();
      set_port(2, 1'b0, 2, 2, 1'b0);
      #1;
      check("pri_bubble", grant, 4'h0);
      tick();
      check("pri_wreq", grant, 4'h2);
      tick();
      clear_all();
      tick();

      // 5: wreq aging with STARVE_LIMIT=2
      do_reset();
      set_port(0, 1'b1, 2, 0, 1'b1);
      set_port(1, 1'b1, 2, 2, 1'b1);
      set_port(2, 1'b1, 2, 2, 1'b1);
      tick();
      check("age_rresp1", grant, 4'h2);
      tick();
      set_port(1, 1'b0, 2, 2, 1'b1);
      #1;
      check("age_bubble1", grant, 4'h0);
      tick();
      check("age_rresp2", grant, 4'h4);
      tick();
      set_port(2, 1'b0, 2, 2, 1'b1);
      set_port(1, 1'b1, 2, 2, 1'b1);
      tick();
      check("age_wreq", grant, 4'h1);
      tick();
      tick();
      check("age_cleared", grant, 4'h2);
      tick();
      clear_all();
      tick();

      // 6: timeout after an idle gap, pending p1 served next
      do_reset();
      set_port(0, 1'b1, 2, 1, 1'b0);
      set_port(1, 1'b1, 2, 1, 1'b1);
      tick();
      check("to_grant0", grant, 4'h1);
      tick();
      set_port(0, 1'b0, 2, 1, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         tick();
         check($sformatf("to_wait%0d", i), {30'd0, busy, abort}, 32'h2);
      end
      tick();
      check("to_abort", abort, 1'b1);
      check("to_busy", busy, 1'b0);
      check("to_grant_clr", grant, 4'h0);
      tick();
      check("to_abort_pulse", abort, 1'b0);
      check("to_grant1", grant, 4'h2);
      tick();
      clear_all();

      // Reset mid-frame drops the grant
      set_port(2, 1'b1, 2, 1, 1'b0);
      tick(); tick();
      check("mid_grant", grant, 4'h4);
      rst = 1'b1;
      #1;
      check("mid_rdy_comb", req_ready, 4'h0);
      tick();
      check("mid_grant_clr", grant, 4'h0);
      check("mid_busy_clr", busy, 1'b0);
      rst = 1'b0;
      clear_all();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
